uart_tx_arbiter: RTL and testbench

//   Shares one uart_transmitter between NUM_REQ byte producers.

---
 rtl/uart_tx_arbiter_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_picker.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: byte/bit aliases and the sequencer states.
package uart_tx_arbiter_pkg;

  typedef logic       bit_t;
  typedef logic [7:0] uint8_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module uart_tx_arbiter_rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic               valid,
  output logic [REQ_W-1:0]   win
);

  logic [NUM_REQ-1:0]            hit;
  logic [NUM_REQ-1:0][REQ_W-1:0] rot_idx;

  // rot_idx[gi] is the requester sitting gi places after the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [REQ_W:0] sum;
    assign sum = {1'b0, ptr} + (REQ_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (REQ_W+1)'(NUM_REQ)) ? REQ_W'(sum - (REQ_W+1)'(NUM_REQ))
                                                      : sum[REQ_W-1:0];
    assign hit[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    valid = |req;
    win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) win = rot_idx[i];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_transmitter among NUM_REQ byte producers: round-robin grant,
// launch with timeout, wait for the frame to drain, then ack the owner.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int LAUNCH_TIMEOUT = 16,
  localparam int REQ_W          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_transmit,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 active,
  output logic [REQ_W-1:0]     grant_id,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(LAUNCH_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE      = IDLE;
  localparam logic [1:0] ST_LAUNCH    = LAUNCH;
  localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

  logic [1:0]         state_reg;
  logic [REQ_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NUM_REQ-1:0] ack_reg;
  logic               tx_transmit_reg;
  uint8_t             tx_data_reg;
  logic               active_reg;
  logic [REQ_W-1:0]   grant_id_reg;
  logic               timeout_err_reg;

  bit_t               pick_valid;
  logic [REQ_W-1:0]   pick_id;
  uint8_t             req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = req_data[gi*8 +: 8];
  end

  uart_tx_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .win   (pick_id)
  );

  function automatic logic [REQ_W-1:0] wrap_inc(input logic [REQ_W-1:0] id);
    return (id == REQ_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      ack_reg         <= '0;
      tx_transmit_reg <= 1'b0;
      tx_data_reg     <= '0;
      active_reg      <= 1'b0;
      grant_id_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      ack_reg         <= '0;
      timeout_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A busy transmitter is still draining someone's frame; hold off.
          if (pick_valid && !tx_busy) begin
            tx_data_reg  <= req_byte[pick_id];
            grant_id_reg <= pick_id;
            active_reg   <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (tx_busy) begin
            tx_transmit_reg <= 1'b0;
            cnt_reg         <= '0;
            state_reg       <= ST_WAIT_DONE;
          end else if (cnt_reg == CNT_W'(LAUNCH_TIMEOUT - 1)) begin
            timeout_err_reg <= 1'b1;
            tx_transmit_reg <= 1'b0;
            active_reg      <= 1'b0;
            ptr_reg         <= wrap_inc(grant_id_reg);
            cnt_reg         <= '0;
            state_reg       <= ST_IDLE;
          end else begin
            tx_transmit_reg <= 1'b1;
            cnt_reg         <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            ack_reg[grant_id_reg] <= 1'b1;
            active_reg            <= 1'b0;
            ptr_reg               <= wrap_inc(grant_id_reg);
            state_reg             <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ack         = ack_reg;
  assign tx_transmit = tx_transmit_reg;
  assign tx_data     = tx_data_reg;
  assign active      = active_reg;
  assign grant_id    = grant_id_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter (busy 1 cycle after transmit, 10 cycles long).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_transmit;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        active;
  logic [1:0]  grant_id;
  logic        timeout_err;

  logic [7:0]  data_tab [4];
  logic        force_en;
  logic        force_val;
  logic        model_busy;
  logic [7:0]  model_data;
  int          busy_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          overlap_cnt = 0;
  int          ack_q [$];
  logic [7:0]  data_q [$];

  always #5 clk = ~clk;

  assign req_data = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
  assign tx_busy  = force_en ? force_val : model_busy;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .LAUNCH_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_transmit (tx_transmit),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .active      (active),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  // Behavioural uart_transmitter.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
      model_data <= 8'h00;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) model_busy <= 1'b0;
    end else if (tx_transmit && !force_en) begin
      model_busy <= 1'b1;
      busy_cnt   <= 10;
      model_data <= tx_data;
    end
  end

  always @(negedge clk) begin
    if (reset && (($countones(ack) > 1) || ((ack != 4'b0) && timeout_err)))
      overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (tx_busy !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq(tag, 32'(tx_busy), 32'(lvl));
  endtask

  // Drive req=mask and collect nframes acks; producers drop their req on ack when drop=1.
  task automatic run_frames(input logic [3:0] mask, input int nframes, input bit drop);
    int got = 0;
    int cyc = 0;
    ack_q.delete();
    data_q.delete();
    req = mask;
    while (got < nframes && cyc < 40 * nframes + 40) begin
      @(negedge clk);
      cyc++;
      if (ack != 4'b0) begin
        for (int i = 0; i < 4; i++) begin
          if (ack[i]) begin
            ack_q.push_back(i);
            data_q.push_back(model_data);
            if (drop) req[i] = 1'b0;
          end
        end
        got++;
      end
    end
    req = 4'b0;
    if (got != nframes) check_eq("frame_budget", 32'(got), 32'(nframes));
  endtask

  task automatic check_order(input string tag, input int exp [8], input int n);
    check_eq({tag, "_count"}, 32'(ack_q.size()), 32'(n));
    for (int j = 0; j < n && j < ack_q.size(); j++) begin
      check_eq($sformatf("%s_id%0d", tag, j), 32'(ack_q[j]), 32'(exp[j]));
      check_eq($sformatf("%s_data%0d", tag, j), 32'(data_q[j]), 32'(data_tab[exp[j]]));
    end
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    req       = 4'b0;
    force_en  = 1'b0;
    force_val = 1'b0;
    for (int i = 0; i < 4; i++) data_tab[i] = 8'h00;

    // Reset values
    tick(3);
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_transmit", 32'(tx_transmit), 32'h0);
    check_eq("rst_data", 32'(tx_data), 32'h0);
    check_eq("rst_active", 32'(active), 32'h0);
    check_eq("rst_grant", 32'(grant_id), 32'h0);
    check_eq("rst_timeout", 32'(timeout_err), 32'h0);
    reset = 1'b1;
    tick(1);

    // 1: single request from 1 with A5
    data_tab[1] = 8'hA5;
    req = 4'b0010;
    tick(1);
    check_eq("t1_active", 32'(active), 32'h1);
    check_eq("t1_grant", 32'(grant_id), 32'h1);
    check_eq("t1_data", 32'(tx_data), 32'hA5);
    check_eq("t1_transmit_early", 32'(tx_transmit), 32'h0);
    req = 4'b0;
    data_tab[1] = 8'h3C;
    tick(1);
    check_eq("t1_transmit", 32'(tx_transmit), 32'h1);
    tick(2);
    check_eq("t1_transmit_drop", 32'(tx_transmit), 32'h0);
    wait_busy(1'b0, "t1_busy_fall");
    check_eq("t1_ack_early", 32'(ack), 32'h0);
    tick(1);
    check_eq("t1_ack", 32'(ack), 32'h2);
    check_eq("t1_active_off", 32'(active), 32'h0);
    check_eq("t1_sent", 32'(model_data), 32'hA5);
    check_eq("t1_data_held", 32'(tx_data), 32'hA5);
    tick(1);
    check_eq("t1_ack_pulse", 32'(ack), 32'h0);

    data_tab[0] = 8'h10;
    data_tab[1] = 8'h21;
    data_tab[2] = 8'h42;
    data_tab[3] = 8'h83;

    // 2: simultaneous 0 and 2 under various pointer positions
    run_frames(4'b1000, 1, 1'b1);
    check_order("t2a", '{3, 0, 0, 0, 0, 0, 0, 0}, 1);
    run_frames(4'b0101, 2, 1'b1);
    check_order("t2b", '{0, 2, 0, 0, 0, 0, 0, 0}, 2);
    run_frames(4'b0101, 2, 1'b1);
    check_order("t2c_ptr3", '{0, 2, 0, 0, 0, 0, 0, 0}, 2);
    run_frames(4'b0010, 1, 1'b1);
    check_order("t2d", '{1, 0, 0, 0, 0, 0, 0, 0}, 1);
    run_frames(4'b0101, 2, 1'b1);
    check_order("t2e_ptr2", '{2, 0, 0, 0, 0, 0, 0, 0}, 2);

    // 3: all four held for 8 frames from pointer 0
    run_frames(4'b1000, 1, 1'b1);
    check_order("t3_pre", '{3, 0, 0, 0, 0, 0, 0, 0}, 1);
    run_frames(4'b1111, 8, 1'b0);
    check_order("t3", '{0, 1, 2, 3, 0, 1, 2, 3}, 8);

    // 4: busy stuck low -> launch timeout, next requester granted
    tick(1);
    force_en  = 1'b1;
    force_val = 1'b0;
    req = 4'b0011;
    tick(1);
    check_eq("t4_grant0", 32'(grant_id), 32'h0);
    check_eq("t4_active", 32'(active), 32'h1);
    n = 0;
    while (!timeout_err && n < 40) begin
      tick(1);
      n++;
    end
    check_eq("t4_timeout_cycle", 32'(n), 32'd16);
    check_eq("t4_transmit_off", 32'(tx_transmit), 32'h0);
    check_eq("t4_active_off", 32'(active), 32'h0);
    check_eq("t4_no_ack", 32'(ack), 32'h0);
    tick(1);
    check_eq("t4_timeout_pulse", 32'(timeout_err), 32'h0);
    check_eq("t4_next_grant", 32'(grant_id), 32'h1);
    check_eq("t4_next_active", 32'(active), 32'h1);
    force_en = 1'b0;
    run_frames(4'b0010, 1, 1'b1);
    check_order("t4_after", '{1, 0, 0, 0, 0, 0, 0, 0}, 1);

    // 5: busy high at reset release blocks the grant
    tick(1);
    reset     = 1'b0;
    force_en  = 1'b1;
    force_val = 1'b1;
    req = 4'b1000;
    tick(2);
    reset = 1'b1;
    tick(4);
    check_eq("t5_blocked_active", 32'(active), 32'h0);
    check_eq("t5_blocked_transmit", 32'(tx_transmit), 32'h0);
    force_en = 1'b0;
    tick(1);
    check_eq("t5_grant", 32'(grant_id), 32'h3);
    check_eq("t5_active", 32'(active), 32'h1);
    run_frames(4'b1000, 1, 1'b1);
    check_order("t5", '{3, 0, 0, 0, 0, 0, 0, 0}, 1);

    // 6a: requester 2 drops req mid-frame, still acked
    tick(1);
    req = 4'b0100;
    wait_busy(1'b1, "t6a_busy");
    req = 4'b0;
    run_frames(4'b0000, 1, 1'b1);
    check_order("t6a", '{2, 0, 0, 0, 0, 0, 0, 0}, 1);

    // 6b: reset during WAIT_DONE
    tick(1);
    req = 4'b0100;
    wait_busy(1'b1, "t6b_busy");
    tick(2);
    check_eq("t6b_active_pre", 32'(active), 32'h1);
    reset = 1'b0;
    req = 4'b0;
    #1;
    check_eq("t6b_transmit", 32'(tx_transmit), 32'h0);
    check_eq("t6b_active", 32'(active), 32'h0);
    check_eq("t6b_grant", 32'(grant_id), 32'h0);
    check_eq("t6b_data", 32'(tx_data), 32'h0);
    tick(2);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ack != 4'b0) n++;
    end
    check_eq("t6b_no_ack", 32'(n), 32'h0);

    check_eq("no_overlap", 32'(overlap_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
